// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave frame decoder -> single-cycle register read/write strobes, all in clk domain.
// Optional SPI_SLAVE_ADDR_AUTOINC_EN: burst mode with address auto-increment per data word.
module spi_slave_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_csb,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    sclk_q;
  logic                    csb_q;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    csb_fall;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ADDR_WIDTH-1:0]   cmd_sh;
  logic [ADDR_WIDTH:0]     cmd_next;
  logic [DATA_WIDTH-2:0]   data_sh;
  logic [DATA_WIDTH-1:0]   data_next;
  logic [DATA_WIDTH-1:0]   tx_sh;
  logic                    miso_q;
  logic                    rw_q;
  logic                    rd_q;
  logic                    cnt_clr;
  logic                    addr_ld;
  logic                    wdata_ld;
  logic                    rd_set;
  logic                    wr_set;

  assign sclk_rise = spi_sclk & ~sclk_q;
  assign sclk_fall = ~spi_sclk & sclk_q;
  assign csb_fall  = ~spi_csb & csb_q;

  assign cmd_next  = {cmd_sh, spi_mosi};
  assign data_next = {data_sh, spi_mosi};

  assign spi_miso  = miso_q & rw_q & (state == DATA);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    addr_ld   = 1'b0;
    wdata_ld  = 1'b0;
    rd_set    = 1'b0;
    wr_set    = 1'b0;
    if (spi_csb) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (csb_fall) begin
            state_nxt = CMD;
            cnt_clr   = 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise && bit_cnt == CMD_LAST) begin
            addr_ld   = 1'b1;
            cnt_clr   = 1'b1;
            rd_set    = cmd_next[ADDR_WIDTH];
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (sclk_rise && bit_cnt == DATA_LAST) begin
            cnt_clr = 1'b1;
            if (!rw_q) begin
              wdata_ld = 1'b1;
              wr_set   = 1'b1;
            end
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
            // next burst word: prefetch the following register so it shifts out gap-free
            rd_set = rw_q;
`else
            state_nxt = DONE;
`endif
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sclk_q      <= 1'b0;
      // Reset as "selected" so a CSB already low when reset releases is not seen as a frame start
      csb_q       <= 1'b0;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      data_sh     <= '0;
      tx_sh       <= '0;
      miso_q      <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      sclk_q      <= spi_sclk;
      csb_q       <= spi_csb;
      spi_miso_oe <= ~spi_csb;
      reg_wr      <= wr_set;
      reg_rd      <= rd_set;
      rd_q        <= reg_rd;

      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (sclk_rise && (state == CMD || state == DATA)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state == CMD && sclk_rise) begin
        cmd_sh <= cmd_next[ADDR_WIDTH-1:0];
      end
      if (state == DATA && sclk_rise && !rw_q) begin
        data_sh <= data_next[DATA_WIDTH-2:0];
      end
      if (wdata_ld) begin
        reg_wdata <= data_next;
      end

      if (addr_ld) begin
        reg_addr <= cmd_next[ADDR_WIDTH-1:0];
        rw_q     <= cmd_next[ADDR_WIDTH];
      end
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
      else if (reg_wr || (rd_set && state == DATA)) begin
        reg_addr <= reg_addr + ADDR_WIDTH'(1);
      end
`endif

      // reg_rdata is valid the cycle after reg_rd; each fall presents the next bit, MSB first
      if (rd_q) begin
        tx_sh <= reg_rdata;
      end else if (state == DATA && rw_q && sclk_fall) begin
        miso_q <= tx_sh[DATA_WIDTH-1];
        tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      end
      if (addr_ld) begin
        miso_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: strobe scoreboard plus MISO sampling on SCLK rises.
module tb_spi_slave_ctrl;

  localparam int HALF = 5;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_csb = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic [15:0] rdata_val = 16'h0000;
  logic        rd_dly = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  wr_exp_t    wr_q[$];
  logic [6:0] rd_q[$];

  spi_slave_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_csb    (spi_csb),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata)
  );

  always #5 clk = ~clk;

  // Register file model: read data only valid on the cycle after reg_rd
  always @(posedge clk) rd_dly <= reg_rd;
  assign reg_rdata = rd_dly ? rdata_val : 16'hDEAD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {57'd0, reg_addr}, 64'hFFFF);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("wr_addr", {57'd0, reg_addr}, {57'd0, e.addr});
          chk("wr_data", {48'd0, reg_wdata}, {48'd0, e.data});
        end
      end
      if (reg_rd) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", {57'd0, reg_addr}, 64'hFFFF);
        end else begin
          logic [6:0] a;
          a = rd_q.pop_front();
          chk("rd_addr", {57'd0, reg_addr}, {57'd0, a});
        end
      end
    end
  end

  task automatic sclk_bit(input logic b, output logic so);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    so = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n, output logic [63:0] so);
    logic b;
    so = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sclk_bit(bits[i], b);
      so = {so[62:0], b};
    end
  endtask

  task automatic csb_low();
    spi_csb = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csb_high();
    repeat (HALF) @(negedge clk);
    spi_csb = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_wr_pending"}, 64'(wr_q.size()), 64'd0);
    chk({tag, "_rd_pending"}, 64'(rd_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] so;
    wr_q.delete();
    rd_q.delete();

    repeat (4) @(negedge clk);
    chk("reset_outs", {29'd0, spi_miso, spi_miso_oe, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_oe", {63'd0, spi_miso_oe}, 64'd0);

    // single write
    wr_q.push_back('{addr: 7'h12, data: 16'hA5C3});
    csb_low();
    shift_bits({40'd0, 1'b0, 7'h12, 16'hA5C3}, 24, so);
    csb_high();
    chk_drained("write");

    // single read
    rdata_val = 16'h8001;
    rd_q.push_back(7'h05);
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
    rd_q.push_back(7'h06);
`endif
    csb_low();
    chk("read_oe_low", {63'd0, spi_miso_oe}, 64'd1);
    shift_bits({40'd0, 1'b1, 7'h05, 16'h0000}, 24, so);
    chk("read_miso", {48'd0, so[15:0]}, 64'h8001);
    csb_high();
    chk("read_oe_high", {63'd0, spi_miso_oe}, 64'd0);
    chk("read_miso_idle", {63'd0, spi_miso}, 64'd0);
    chk_drained("read");

    // abort after 10 data bits, then a clean write
    csb_low();
    shift_bits({46'd0, 1'b0, 7'h33, 10'h2AB}, 18, so);
    csb_high();
    chk_drained("abort");
    wr_q.push_back('{addr: 7'h01, data: 16'h0001});
    csb_low();
    shift_bits({40'd0, 1'b0, 7'h01, 16'h0001}, 24, so);
    csb_high();
    chk_drained("after_abort");

    // reset mid-CMD, frame started under reset is discarded
    csb_low();
    shift_bits({60'd0, 4'b1010}, 4, so);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {29'd0, spi_miso, spi_miso_oe, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);
    spi_csb = 1'b1;
    repeat (2) @(negedge clk);
    spi_csb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits({40'd0, 1'b0, 7'h44, 16'hBEEF}, 24, so);
    csb_high();
    chk_drained("rst_frame");
    wr_q.push_back('{addr: 7'h22, data: 16'h5A5A});
    csb_low();
    shift_bits({40'd0, 1'b0, 7'h22, 16'h5A5A}, 24, so);
    csb_high();
    chk_drained("post_rst");

    // 24-bit write plus 8 extra clocks
    wr_q.push_back('{addr: 7'h2A, data: 16'h1234});
    csb_low();
    shift_bits({32'd0, 1'b0, 7'h2A, 16'h1234, 8'hFF}, 32, so);
    csb_high();
    chk_drained("extra_clk");

    // three-word write starting at the top address
    wr_q.push_back('{addr: 7'h7F, data: 16'h1111});
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
    wr_q.push_back('{addr: 7'h00, data: 16'h2222});
    wr_q.push_back('{addr: 7'h01, data: 16'h3333});
`endif
    csb_low();
    shift_bits({8'd0, 1'b0, 7'h7F, 16'h1111, 16'h2222, 16'h3333}, 56, so);
    csb_high();
    chk_drained("burst");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave transaction controller running entirely in the system `clk` domain. Consumes the SPI pins after they have passed through the two-flop input synchronizers, detects SCLK/CSB edges, decodes a fixed-format command frame and turns it into single-cycle register-bus read/write strobes. Sits between the synchronized SPI pins and the register file of the FPGA design; SPI mode 0 (CPOL=0, CPHA=0), MSB first.

## Interface
- `ADDR_WIDTH`, 7, register address width; command field is 1 R/W bit + `ADDR_WIDTH` bits.
- `DATA_WIDTH`, 16, register data width and data-phase length in bits.

- `clk`  input  1  system clock; must be ≥ 8× SCLK frequency.
- `rst`  input  1  synchronous, active-high reset.
- `spi_csb`  input  1  chip select, active low, already synchronized to `clk`.
- `spi_sclk`  input  1  serial clock, already synchronized.
- `spi_mosi`  input  1  serial data in, already synchronized.
- `spi_miso`  output  1  serial data out.
- `spi_miso_oe`  output  1  MISO output enable for the top-level tristate.
- `reg_addr`  output  ADDR_WIDTH  register address, stable from strobe until next frame.
- `reg_wdata`  output  DATA_WIDTH  write data, valid with `reg_wr`.
- `reg_wr`  output  1  one-cycle write strobe.
- `reg_rd`  output  1  one-cycle read strobe.
- `reg_rdata`  input  DATA_WIDTH  read data; valid on the cycle after `reg_rd`.

## Operation
- Edge detect: register previous `spi_sclk`/`spi_csb`; `sclk_rise`, `sclk_fall`, `csb_fall` are single-cycle pulses.
- Frame: bit 0 = R/W (1 = read, 0 = write), then `ADDR_WIDTH` address bits, then `DATA_WIDTH` data bits; MOSI sampled on `sclk_rise`.
- States:
  - IDLE: wait for `csb_fall`; clear bit counter → CMD.
  - CMD: shift MOSI on each `sclk_rise`; after 1+ADDR_WIDTH bits latch `reg_addr`; read → pulse `reg_rd`, → DATA; write → DATA.
  - DATA: write: shift MOSI; on the DATA_WIDTH-th rise load `reg_wdata`, pulse `reg_wr`, → DONE. Read: on the cycle after `reg_rd` capture `reg_rdata` into the TX shifter; on each `sclk_fall` present the next bit, MSB first; after DATA_WIDTH rises → DONE.
  - DONE: ignore SCLK until CSB high.
- CSB high in any state → IDLE next cycle; a partial frame issues no `reg_wr`. An issued `reg_rd` is not retracted.
- `spi_miso` = TX shifter MSB while in DATA of a read, else 0. `spi_miso_oe` = 1 while CSB low, else 0.
- Extra SCLK edges after the frame are ignored. A new `csb_fall` is required for the next frame.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, state IDLE, counters 0.
- `reg_rd` is asserted on the cycle after the `sclk_rise` that samples the last address bit. `reg_rdata` is captured one cycle later.
- The first read data bit drives `spi_miso` on the cycle after the next `sclk_fall`, i.e. before the first data-phase rise. The ≥8× clock ratio guarantees this.
- `reg_wr` is asserted on the cycle after the `sclk_rise` that samples the last data bit. `reg_wdata` and `reg_addr` are valid in that cycle.
- `rst` mid-frame: outputs return to reset values next cycle; the frame is discarded; wait for a fresh `csb_fall`.

## Configuration
- `SPI_SLAVE_ADDR_AUTOINC_EN` defined: burst mode.
  - After each data word, DATA continues instead of entering DONE.
  - `reg_addr` increments by 1, wrapping modulo 2^ADDR_WIDTH.
  - Write: `reg_wr` is issued per completed word.
  - Read: a new `reg_rd` is issued on the cycle after the last bit's rise; the next word shifts out without gap.
  - Burst ends on CSB high.
- Undefined: one word per frame; DONE after the first word.

## Test plan
- Write: CSB low, shift 0 / 7'h12 / 16'hA5C3, CSB high → exactly one `reg_wr` with `reg_addr`=7'h12 and `reg_wdata`=16'hA5C3; `reg_rd` never asserted.
- Read: shift 1 / 7'h05, with `reg_rdata`=16'h8001 → one `reg_rd` at addr 7'h05; MISO bits sampled on 16 rises = 16'h8001; `spi_miso_oe`=1 only while CSB low.
- Abort: write frame, CSB high after 10 data bits → no `reg_wr`. Following full write to 7'h01 with 16'h0001 → single correct `reg_wr`.
- Reset mid-frame: assert `rst` during CMD → all outputs at reset values next cycle. A frame started before `rst` deasserts produces no strobe; the next full frame succeeds.
- Extra clocks: 24-bit write followed by 8 extra SCLKs before CSB high → exactly one `reg_wr`.
- With `SPI_SLAVE_ADDR_AUTOINC_EN`: write burst at 7'h7F with 3 words → `reg_wr` at addresses 7'h7F, 7'h00, 7'h01 (wrap). Without the macro → one `reg_wr` at 7'h7F only.
